// File: rtl/regfile_wb_sb.sv
// regfile_wb_sb
//   Register file for the pipelined datapath: two combinational read ports,
//   two clocked write ports (E and M) and a per-register pending scoreboard
//   used by decode to detect hazards against in-flight producers.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   srcA/srcB -> valA/valB   combinational reads (0 for RNONE / out of range)
//   dstE/valE, dstM/valM     write ports; M wins when both target one register
//   claim_valid/claim_dst    mark a register pending for an issuing producer
//   hazA/hazB                source is pending and not satisfied this cycle
//   addr_err                 some active ID lies in NUM_REGS..RNONE-1
//   regs_flat                all registers, register i at [i*DATA_W +: DATA_W]
module regfile_wb_sb #(
    parameter int                 DATA_W     = 64,
    parameter int                 NUM_REGS   = 15,
    parameter int                 ADDR_W     = 4,
    parameter logic [ADDR_W-1:0]  RNONE      = {ADDR_W{1'b1}},
    parameter int                 RSP_IDX    = 4,
    parameter logic [DATA_W-1:0]  STACK_INIT = '0,
    parameter int                 BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            srcA,
    input  logic [ADDR_W-1:0]            srcB,
    output logic [DATA_W-1:0]            valA,
    output logic [DATA_W-1:0]            valB,
    input  logic [ADDR_W-1:0]            dstE,
    input  logic [DATA_W-1:0]            valE,
    input  logic [ADDR_W-1:0]            dstM,
    input  logic [DATA_W-1:0]            valM,
    input  logic                         claim_valid,
    input  logic [ADDR_W-1:0]            claim_dst,
    output logic                         hazA,
    output logic                         hazB,
    output logic                         addr_err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NREG_W = (ADDR_W+1)'(NUM_REGS);
    localparam bit              BYP    = (BYPASS != 0);

    function automatic logic id_valid(input logic [ADDR_W-1:0] id);
        return ({1'b0, id} < NREG_W) && (id != RNONE);
    endfunction

    function automatic logic id_bad(input logic [ADDR_W-1:0] id);
        return ({1'b0, id} >= NREG_W) && (id != RNONE);
    endfunction

    logic                e_ok;
    logic                m_ok;
    logic                c_ok;
    logic [NUM_REGS-1:0] pending;

    assign e_ok = id_valid(dstE);
    assign m_ok = id_valid(dstM);
    assign c_ok = claim_valid && id_valid(claim_dst);

    assign addr_err = id_bad(srcA) || id_bad(srcB) || id_bad(dstE) ||
                      id_bad(dstM) || (claim_valid && id_bad(claim_dst));

    genvar gi;

    // Storage and scoreboard bit for each architectural register.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] ID      = ADDR_W'(gi);
            localparam logic [DATA_W-1:0] RST_VAL = (gi == RSP_IDX) ? STACK_INIT : '0;

            logic [DATA_W-1:0] data_reg;
            logic              pend_reg;
            logic              hit_e;
            logic              hit_m;
            logic              hit_c;

            assign hit_e = e_ok && (dstE == ID);
            assign hit_m = m_ok && (dstM == ID);
            assign hit_c = c_ok && (claim_dst == ID);

            // M is checked first so that dstE == dstM keeps valM.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= RST_VAL;
                end else if (hit_m) begin
                    data_reg <= valM;
                end else if (hit_e) begin
                    data_reg <= valE;
                end
            end

            // A new claim outranks a retiring write: the newer producer
            // still owes this register a value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_reg <= 1'b0;
                end else if (hit_c) begin
                    pend_reg <= 1'b1;
                end else if (hit_e || hit_m) begin
                    pend_reg <= 1'b0;
                end
            end

            assign regs_flat[gi*DATA_W +: DATA_W] = data_reg;
            assign pending[gi]                    = pend_reg;
        end
    endgenerate

    // Read ports: index 0 is A, index 1 is B.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] src;
            logic [DATA_W-1:0] stored;
            logic              pend;
            logic [DATA_W-1:0] val;
            logic              haz;
            logic              fwd_m;
            logic              fwd_e;

            assign src = (gi == 0) ? srcA : srcB;

            always_comb begin
                stored = '0;
                pend   = 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (src == ADDR_W'(i)) begin
                        stored = regs_flat[i*DATA_W +: DATA_W];
                        pend   = pending[i];
                    end
                end
            end

            // src is known valid wherever these are used, so matching it
            // also implies the write port targets a real register.
            assign fwd_m = BYP && (dstM == src);
            assign fwd_e = BYP && (dstE == src);

            always_comb begin
                val = '0;
                haz = 1'b0;
                if (id_valid(src)) begin
                    if (fwd_m) begin
                        val = valM;
                    end else if (fwd_e) begin
                        val = valE;
                    end else begin
                        val = stored;
                    end
                    haz = pend && !(fwd_m || fwd_e);
                end
            end
        end
    endgenerate

    assign valA = g_rd[0].val;
    assign valB = g_rd[1].val;
    assign hazA = g_rd[0].haz;
    assign hazB = g_rd[1].haz;

endmodule

// File: doc/regfile_wb_sb.md
Name: regfile_wb_sb

Overview:
- Parametrised successor to the SEQ decode/writeback register file, sized for the PIPE datapath.
- Provides two combinational read ports (srcA/srcB) and two clocked write ports (E and M).
- Optional same-cycle write-to-read bypass.
- Per-register pending scoreboard so decode can detect data hazards against in-flight producers.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 15, number of architectural registers (index 0..NUM_REGS-1).
- ADDR_W, 4, register-ID width.
- RNONE, 4'hF, "no register" ID; never read or written.
- RSP_IDX, 4, index of the stack pointer.
- STACK_INIT, 64'd0, reset value of register RSP_IDX.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- srcA  in  ADDR_W  read port A register ID.
- srcB  in  ADDR_W  read port B register ID.
- valA  out  DATA_W  read port A data.
- valB  out  DATA_W  read port B data.
- dstE  in  ADDR_W  E-port write target (RNONE = no write).
- valE  in  DATA_W  E-port write data.
- dstM  in  ADDR_W  M-port write target (RNONE = no write).
- valM  in  DATA_W  M-port write data.
- claim_valid  in  1  mark claim_dst pending this cycle.
- claim_dst  in  ADDR_W  register claimed by an issuing instruction.
- hazA  out  1  srcA is pending and not resolved by a same-cycle write.
- hazB  out  1  srcB is pending and not resolved by a same-cycle write.
- addr_err  out  1  any active ID is >= NUM_REGS and != RNONE.
- regs_flat  out  NUM_REGS*DATA_W  all registers; register i at bits [i*DATA_W +: DATA_W], for debug and testbench.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers clear to 0, except register RSP_IDX, which loads STACK_INIT.
  - All pending bits clear to 0.
  - Reset asserted mid-operation discards any write or claim in that cycle.
  - Outputs reflect reset state immediately: valA/valB show the reset contents; hazA/hazB = 0.
- Reads (combinational, 0-cycle latency):
  - srcX == RNONE or srcX >= NUM_REGS: valX = 0 and hazX = 0.
  - Otherwise valX = stored value.
  - With BYPASS=1: if dstM == srcX, valX = valM; else if dstE == srcX, valX = valE. M has priority.
- Writes (on posedge clk, rst low):
  - reg[dstE] <= valE when dstE is valid.
  - reg[dstM] <= valM when dstM is valid.
  - dstE == dstM (valid): valM is written and valE is dropped (popq %rsp convention).
  - A write to RNONE or to an out-of-range ID is ignored.
- Scoreboard (pending[i], one bit per register):
  - Set on posedge when claim_valid is high and claim_dst is valid.
  - Cleared on posedge when dstE or dstM equals i.
  - Set and clear of the same register in the same cycle: the set wins, so the register stays pending for the newer producer.
  - A claim while already pending leaves the bit set; there is no counting.
  - hazX = pending[srcX] AND NOT (BYPASS AND (dstE == srcX OR dstM == srcX)).
- addr_err:
  - Combinational OR over srcA, srcB, dstE, dstM and claim_dst (gated by claim_valid).
  - Asserts for any ID in NUM_REGS..RNONE-1.
  - Has no side effects.
- Widths: data is passed through unmodified, with no sign or width conversion. With the default NUM_REGS=15, ID 4'hE is the top valid register.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with STACK_INIT=64'h200 -> regs_flat shows rsp=0x200 and all others 0 immediately; hazA=hazB=0.
- Dual write with readback: dstE=0, valE=12 and dstM=3, valM=7 for one cycle -> next cycle srcA=0 gives valA=12 and srcB=3 gives valB=7.
- Write conflict: dstE=dstM=4, valE=0x1F8, valM=0x55 -> rsp=0x55 afterwards.
- Bypass: BYPASS=1, srcA=2, dstE=2, valE=99 -> valA=99 in the same cycle. BYPASS=0, same stimulus -> valA = old value, then 99 the next cycle.
- Scoreboard:
  - claim_dst=1 -> hazA=1 for srcA=1.
  - In a later cycle, drive claim_dst=1 together with dstE=1 -> pending stays 1.
  - dstM=1 alone -> pending clears; hazA=0 in the following cycle.
- RNONE and out-of-range: srcA=4'hF -> valA=0, hazA=0, addr_err=0. dstE=4'hF -> no register changes. With NUM_REGS=8, srcB=9 -> valB=0, addr_err=1.
